// File: rtl/sram_standby_wrapper.sv
// Parametrised single-port SRAM wrapper with a drain/gate/wake standby controller.
// Also holds the bit-masked SRAM model that the wrapper drives through a latch-based clock gate.

module sram_bitmask_model #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              n_cs_i,
  input  logic              n_we_i,
  input  logic              n_oe_i,
  input  logic [DATA_W-1:0] mask_i,
  input  logic [ADDR_W-1:0] ad_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = IDX_W'(ad_i);
  assign in_range = 32'(ad_i) < 32'(DEPTH);

  // Addresses past the end of the array neither write nor return stored data.
  always_ff @(posedge clk_i) begin
    if (!n_cs_i) begin
      if (!n_we_i) begin
        if (in_range) mem_q[idx] <= (mem_q[idx] & mask_i) | (din_i & ~mask_i);
      end else begin
        rdata_q <= in_range ? mem_q[idx] : '0;
      end
    end
  end

  assign dout_o = n_oe_i ? '0 : rdata_q;
endmodule

module sram_standby_wrapper #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8192,
  parameter int ADDR_W      = 13,
  parameter int WAKE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              standby_req_i,
  output logic              standby_ack_o,
  output logic              ready_o,
  input  logic              n_cs_i,
  input  logic              n_we_i,
  input  logic [DATA_W-1:0] mask_i,
  input  logic [ADDR_W-1:0] ad_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              rd_valid_o,
  output logic              access_err_o,
  input  logic              err_clr_i
);
  localparam int WAKE_N = (WAKE_CYCLES < 1) ? 1 : WAKE_CYCLES;
  localparam int CNT_W  = (WAKE_N > 1) ? $clog2(WAKE_N) : 1;
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_N - 1);

  typedef enum logic [1:0] {ACTIVE, DRAIN, GATED, WAKE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              gate_q;
  logic              ack_q;
  logic              ready_q;
  logic              rd_pend_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] dout_q;
  logic              err_q;

  logic              accept_d;
  logic              drop_d;
  logic              clk_en_l;
  logic              mem_clk;
  logic              mem_we_n;
  logic [DATA_W-1:0] mem_mask;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  assign accept_d = !n_cs_i && ready_q;
  assign drop_d   = !n_cs_i && !ready_q;

  // Enable is captured only while clk is low, so gate_q changes never reach the memory clock mid-pulse.
  always_latch begin
    if (!clk_i) clk_en_l = !gate_q;
  end
  assign mem_clk = clk_i & clk_en_l;

  assign mem_we_n = accept_d ? n_we_i : 1'b1;
  assign mem_mask = accept_d ? mask_i : '1;
  assign mem_ad   = accept_d ? ad_i   : '0;
  assign mem_din  = accept_d ? din_i  : '0;

  sram_bitmask_model #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i (mem_clk),
    .n_cs_i(1'b0),
    .n_we_i(mem_we_n),
    .n_oe_i(1'b0),
    .mask_i(mem_mask),
    .ad_i  (mem_ad),
    .din_i (mem_din),
    .dout_o(mem_dout)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      ack_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (standby_req_i) begin
            state_q <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          state_q <= GATED;
          gate_q  <= 1'b1;
          ack_q   <= 1'b1;
        end
        GATED: begin
          if (!standby_req_i) begin
            state_q <= WAKE;
            gate_q  <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= WAKE_LOAD;
          end
        end
        WAKE: begin
          // A renewed request abandons the wake-up before the counter expires.
          if (standby_req_i) begin
            state_q <= GATED;
            gate_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= ACTIVE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ACTIVE;
          gate_q  <= 1'b0;
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_pend_q  <= accept_d && n_we_i;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) dout_q <= mem_dout;
      if (drop_d) err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign standby_ack_o = ack_q;
  assign ready_o       = ready_q;
  assign dout_o        = dout_q;
  assign rd_valid_o    = rd_valid_q;
  assign access_err_o  = err_q;
endmodule

// File: tb/tb_sram_standby_wrapper.sv
// Self-checking bench for sram_standby_wrapper: directed standby sequences plus random
// accesses, compared against a word-array memory model and a two-edge read timeline.

module tb_sram_standby_wrapper;
  localparam int DW    = 64;
  localparam int DEPTH = 48;
  localparam int AW    = 6;
  localparam int WAKE  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          standbyReq;
  logic          standbyAck;
  logic          ready;
  logic          nCs;
  logic          nWe;
  logic [DW-1:0] mask;
  logic [AW-1:0] ad;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rdValid;
  logic          accessErr;
  logic          errClr;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] memModel [0:DEPTH-1];
  bit            curReady = 1'b1;
  bit            prevRead = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic [DW-1:0] expDout  = '0;
  bit            expErr   = 1'b0;

  sram_standby_wrapper #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .standby_req_i(standbyReq),
    .standby_ack_o(standbyAck),
    .ready_o      (ready),
    .n_cs_i       (nCs),
    .n_we_i       (nWe),
    .mask_i       (mask),
    .ad_i         (ad),
    .din_i        (din),
    .dout_o       (dout),
    .rd_valid_o   (rdValid),
    .access_err_o (accessErr),
    .err_clr_i    (errClr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict from the memory model, sample #1 after the edge.
  task automatic applyStimulus(input bit rst, input bit cs_n, input bit we_n, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] m, input bit req,
                               input bit clr, input bit expRdy, input bit expAck, input string tag);
    bit            acc;
    bit            curRead;
    bit            expValid;
    logic [DW-1:0] curData;
    reset = rst; nCs = cs_n; nWe = we_n; ad = a; din = d; mask = m;
    standbyReq = req; errClr = clr;
    acc     = !cs_n && curReady && !rst;
    curRead = acc && we_n;
    curData = (int'(a) < DEPTH) ? memModel[a] : '0;
    if (acc && !we_n && int'(a) < DEPTH) memModel[a] = (memModel[a] & m) | (d & ~m);
    @(posedge clk);
    #1;
    if (rst) begin
      expErr = 1'b0; expDout = '0; expValid = 1'b0;
    end else begin
      if (!cs_n && !curReady) expErr = 1'b1;
      else if (clr) expErr = 1'b0;
      expValid = prevRead;
      if (prevRead) expDout = prevData;
    end
    checkOutput({tag, ":ready"}, DW'(ready), DW'(expRdy));
    checkOutput({tag, ":ack"}, DW'(standbyAck), DW'(expAck));
    checkOutput({tag, ":rd_valid"}, DW'(rdValid), DW'(expValid));
    checkOutput({tag, ":dout"}, dout, expDout);
    checkOutput({tag, ":err"}, DW'(accessErr), DW'(expErr));
    prevRead = rst ? 1'b0 : curRead;
    prevData = curData;
    curReady = expRdy;
  endtask

  task automatic idle(input bit req, input bit clr, input bit expRdy, input bit expAck, input string tag);
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, '1, req, clr, expRdy, expAck, tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, a, d, m, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, a, '0, '1, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, '1, 1'b0, 1'b0, 1'b1, 1'b0, "reset0");
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, '1, 1'b0, 1'b0, 1'b1, 1'b0, "reset1");

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), {$urandom, $urandom}, '0, "init");

    for (int i = 0; i < 150; i++) begin
      int            op;
      logic [AW-1:0] a;
      logic [DW-1:0] m;
      op = $urandom_range(0, 2);
      a  = AW'($urandom_range(0, 63));
      m  = ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom};
      if (op == 0) wr(a, {$urandom, $urandom}, m, "rand_wr");
      else if (op == 1) rd(a, "rand_rd");
      else idle(1'b0, 1'(($urandom_range(0, 3) == 0)), 1'b1, 1'b0, "rand_idle");
    end

    wr(6'd3, 64'h0000_0000_A5A5_A5A5, '0, "a5_wr");
    rd(6'd3, "a5_rd");
    idle(1'b0, 1'b0, 1'b1, 1'b0, "a5_ret");
    checkOutput("a5_const", dout, 64'h0000_0000_A5A5_A5A5);

    wr(6'd5, '0, '0, "mask_clear");
    wr(6'd5, '1, 64'hFFFF_FFFF_FFFF_0000, "mask_low");
    rd(6'd5, "mask_rd");
    idle(1'b0, 1'b0, 1'b1, 1'b0, "mask_ret");
    checkOutput("mask_low_const", dout, 64'h0000_0000_0000_FFFF);

    wr(6'd6, 64'h1111_1111_1111_1111, '0, "upper_init");
    wr(6'd6, '1, 64'hFFFF_FFFF_0000_0000, "upper_mask");
    rd(6'd6, "upper_rd");
    idle(1'b0, 1'b0, 1'b1, 1'b0, "upper_ret");
    checkOutput("upper_const", dout, 64'h1111_1111_FFFF_FFFF);

    applyStimulus(1'b0, 1'b0, 1'b1, 6'd3, '0, '1, 1'b1, 1'b0, 1'b0, 1'b0, "drain_rd");
    idle(1'b1, 1'b0, 1'b0, 1'b1, "gated_ret");
    checkOutput("drain_data", dout, 64'h0000_0000_A5A5_A5A5);
    idle(1'b1, 1'b0, 1'b0, 1'b1, "gated_hold1");
    idle(1'b1, 1'b0, 1'b0, 1'b1, "gated_hold2");

    applyStimulus(1'b0, 1'b0, 1'b0, 6'd3, 64'h1234, '0, 1'b1, 1'b0, 1'b0, 1'b1, "gated_drop");
    checkOutput("err_set", DW'(accessErr), DW'(1'b1));
    idle(1'b1, 1'b0, 1'b0, 1'b1, "err_sticky");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd3, 64'h5678, '0, 1'b1, 1'b1, 1'b0, 1'b1, "set_wins");
    idle(1'b1, 1'b1, 1'b0, 1'b1, "err_clear");

    idle(1'b0, 1'b0, 1'b0, 1'b0, "wake1");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd3, '0, '1, 1'b0, 1'b0, 1'b0, 1'b0, "wake_drop");
    idle(1'b0, 1'b1, 1'b0, 1'b0, "wake3");
    idle(1'b0, 1'b0, 1'b0, 1'b0, "wake4");
    idle(1'b0, 1'b0, 1'b1, 1'b0, "active_again");

    rd(6'd3, "post_drop_rd");
    idle(1'b0, 1'b0, 1'b1, 1'b0, "post_drop_ret");
    checkOutput("post_drop_const", dout, 64'h0000_0000_A5A5_A5A5);

    idle(1'b1, 1'b0, 1'b0, 1'b0, "ab_drain");
    idle(1'b1, 1'b0, 1'b0, 1'b1, "ab_gated");
    idle(1'b0, 1'b0, 1'b0, 1'b0, "ab_wake1");
    idle(1'b0, 1'b0, 1'b0, 1'b0, "ab_wake2");
    idle(1'b1, 1'b0, 1'b0, 1'b1, "ab_regated");
    idle(1'b1, 1'b0, 1'b0, 1'b1, "ab_hold");

    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, '1, 1'b0, 1'b0, 1'b1, 1'b0, "reset_gated");
    checkOutput("reset_dout", dout, '0);
    rd(6'd3, "retain_rd");
    idle(1'b0, 1'b0, 1'b1, 1'b0, "retain_ret");
    checkOutput("retain_const", dout, 64'h0000_0000_A5A5_A5A5);
    idle(1'b0, 1'b0, 1'b1, 1'b0, "retain_pulse_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
